shift_issue_arbiter: RTL and testbench

SHIFT_ISSUE_ARBITER -- requirements
Module: shift_issue_arbiter

---
 rtl/shift_issue_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_shift_issue_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_arbiter.sv
// shift_issue_arbiter
// Shares one two-stage barrel shifter between an alignment requester and a
// normalization requester. Ops are issued combinationally on the cycle they
// are granted. The shifter result is captured one cycle later and presented
// as a one-cycle res_valid_o pulse. The fixed latency is two cycles.
module shift_issue_arbiter #(
    parameter int unsigned SWR = 26,
    parameter int unsigned EWR = 5
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           a_valid_i,
    output logic           a_ready_o,
    input  logic [SWR-1:0] a_data_i,
    input  logic [EWR-1:0] a_shift_i,
    input  logic           a_lr_i,
    input  logic           a_bit_i,

    input  logic           n_valid_i,
    output logic           n_ready_o,
    input  logic [SWR-1:0] n_data_i,
    input  logic [EWR-1:0] n_shift_i,
    input  logic           n_lr_i,
    input  logic           n_bit_i,

    output logic [SWR-1:0] shft_data_o,
    output logic [EWR-1:0] shft_value_o,
    output logic           shft_lr_o,
    output logic           shft_bit_o,
    input  logic [SWR-1:0] shft_result_i,

    output logic           res_valid_o,
    output logic [SWR-1:0] res_data_o,
    output logic           res_tag_o,
    output logic           busy_o
);

    // Width of the shift-amount bits consumed by the shifter's second stage.
    localparam int unsigned HW = EWR - 3;

    // Round-robin preference: which requester wins when both are valid.
    typedef enum logic {
        PREF_A = 1'b0,
        PREF_N = 1'b1
    } ptr_t;

    ptr_t           ptr_q;
    ptr_t           ptr_d;

    // Stage-2 context: the op the shifter is finishing this cycle.
    logic           s2_valid_q;
    logic [HW-1:0]  s2_shift_q;
    logic           s2_lr_q;
    logic           s2_bit_q;
    logic           s2_tag_q;

    // Result register.
    logic           res_valid_q;
    logic [SWR-1:0] res_data_q;
    logic           res_tag_q;

    // Candidate fields.
    logic           cand_valid;
    logic           cand_is_n;
    logic [SWR-1:0] cand_data;
    logic [EWR-1:0] cand_shift;
    logic           cand_lr;
    logic           cand_bit;

    logic           hazard;
    logic           issue;

    // Choose the candidate: the preferred requester when both are valid, else
    // whichever one is valid.
    always_comb begin
        cand_valid = a_valid_i | n_valid_i;
        cand_is_n  = 1'b0;
        if (a_valid_i && n_valid_i) begin
            cand_is_n = (ptr_q == PREF_N);
        end else begin
            cand_is_n = n_valid_i;
        end
        cand_data  = cand_is_n ? n_data_i  : a_data_i;
        cand_shift = cand_is_n ? n_shift_i : a_shift_i;
        cand_lr    = cand_is_n ? n_lr_i    : a_lr_i;
        cand_bit   = cand_is_n ? n_bit_i   : a_bit_i;
    end

    // Decide whether the candidate may be issued this cycle.
    // Stage 1 of the shifter takes its direction and fill from the shared
    // lr/bit pins. Those pins belong to stage 2 while stage 2 is busy, so a
    // candidate that needs different settings must wait one cycle. It does
    // not hand the slot to the other requester.
    always_comb begin
        hazard = s2_valid_q && ((cand_lr != s2_lr_q) || (cand_bit != s2_bit_q));
        issue  = rst && cand_valid && !hazard;
    end

    // Drive the requester handshakes.
    always_comb begin
        a_ready_o = issue && !cand_is_n;
        n_ready_o = issue &&  cand_is_n;
    end

    // Next-state logic for the round-robin pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = cand_is_n ? PREF_A : PREF_N;
        end
    end

    // Register the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PREF_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Drive the shifter inputs.
    // The low three shift bits always go to the op entering stage 1. The high
    // bits and lr/bit go to stage 2 when it holds an op.
    always_comb begin
        shft_data_o  = '0;
        shft_value_o = '0;
        shft_lr_o    = 1'b0;
        shft_bit_o   = 1'b0;
        if (issue) begin
            shft_data_o  = cand_data;
            shft_value_o = cand_shift;
            shft_lr_o    = cand_lr;
            shft_bit_o   = cand_bit;
        end
        if (s2_valid_q) begin
            shft_value_o[EWR-1:3] = s2_shift_q;
            shft_lr_o             = s2_lr_q;
            shft_bit_o            = s2_bit_q;
        end
    end

    // Load the stage-2 context every cycle. It holds the issued op, or
    // becomes invalid when nothing is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_shift_q <= '0;
            s2_lr_q    <= 1'b0;
            s2_bit_q   <= 1'b0;
            s2_tag_q   <= 1'b0;
        end else if (issue) begin
            s2_valid_q <= 1'b1;
            s2_shift_q <= cand_shift[EWR-1:3];
            s2_lr_q    <= cand_lr;
            s2_bit_q   <= cand_bit;
            s2_tag_q   <= cand_is_n;
        end else begin
            s2_valid_q <= 1'b0;
            s2_shift_q <= '0;
            s2_lr_q    <= 1'b0;
            s2_bit_q   <= 1'b0;
            s2_tag_q   <= 1'b0;
        end
    end

    // Capture the finished shifter output with its tag. Data and tag hold
    // between results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= 1'b0;
        end else begin
            res_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                res_data_q <= shft_result_i;
                res_tag_q  <= s2_tag_q;
            end
        end
    end

    // Drive the result and status outputs.
    always_comb begin
        res_valid_o = res_valid_q;
        res_data_o  = res_data_q;
        res_tag_o   = res_tag_q;
        busy_o      = s2_valid_q | res_valid_q;
    end

endmodule

// File: tb/tb_shift_issue_arbiter.sv
// Testbench for shift_issue_arbiter.
// The bench contains a model of the external two-stage shifter.
// Checking uses three parts:
//  - a table of cycle-by-cycle vectors starting from reset;
//  - a hand-written reset-abort sequence;
//  - randomized traffic compared against a reference model that does the
//    whole shift in one step.
module tb_shift_issue_arbiter;

    localparam int unsigned SWR = 26;
    localparam int unsigned EWR = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           a_valid_i = 1'b0, a_lr_i = 1'b0, a_bit_i = 1'b0;
    logic [SWR-1:0] a_data_i = '0;
    logic [EWR-1:0] a_shift_i = '0;
    logic           n_valid_i = 1'b0, n_lr_i = 1'b0, n_bit_i = 1'b0;
    logic [SWR-1:0] n_data_i = '0;
    logic [EWR-1:0] n_shift_i = '0;
    logic           a_ready_o, n_ready_o;
    logic [SWR-1:0] shft_data_o, shft_result_i, res_data_o;
    logic [EWR-1:0] shft_value_o;
    logic           shft_lr_o, shft_bit_o, res_valid_o, res_tag_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    shift_issue_arbiter #(.SWR(SWR), .EWR(EWR)) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .a_shift_i(a_shift_i), .a_lr_i(a_lr_i), .a_bit_i(a_bit_i),
        .n_valid_i(n_valid_i), .n_ready_o(n_ready_o), .n_data_i(n_data_i),
        .n_shift_i(n_shift_i), .n_lr_i(n_lr_i), .n_bit_i(n_bit_i),
        .shft_data_o(shft_data_o), .shft_value_o(shft_value_o),
        .shft_lr_o(shft_lr_o), .shft_bit_o(shft_bit_o),
        .shft_result_i(shft_result_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_tag_o(res_tag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Shift x by amt positions, filling the vacated positions with b.
    // lr=1 shifts left; lr=0 shifts right.
    function automatic logic [SWR-1:0] shf(input logic [SWR-1:0] x, input int unsigned amt,
                                           input logic lr, input logic b);
        logic [SWR-1:0] r;
        r = x;
        for (int unsigned k = 0; k < amt; k++) begin
            r = lr ? {r[SWR-2:0], b} : {b, r[SWR-1:1]};
        end
        return r;
    endfunction

    // External shifter model.
    // Stage 1 shifts by the low three bits and registers the result.
    // Stage 2 shifts that register by the high bits.
    logic [SWR-1:0] mid = '0;
    always @(posedge clk) mid <= shf(shft_data_o, 32'(shft_value_o[2:0]), shft_lr_o, shft_bit_o);
    assign shft_result_i = shf(mid, 32'({shft_value_o[EWR-1:3], 3'b000}), shft_lr_o, shft_bit_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid_i = 1'b0; a_data_i = '0; a_shift_i = '0; a_lr_i = 1'b0; a_bit_i = 1'b0;
        n_valid_i = 1'b0; n_data_i = '0; n_shift_i = '0; n_lr_i = 1'b0; n_bit_i = 1'b0;
    endtask

    // Hold reset with both requesters valid, check that every output is
    // quiet, then release just after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        a_valid_i = 1'b1; a_data_i = 26'h3ffffff; a_shift_i = 5'd7;
        n_valid_i = 1'b1; n_data_i = 26'h1234567; n_shift_i = 5'd3;
        @(negedge clk);
        chk("rst a_ready", 32'(a_ready_o), 0);
        chk("rst n_ready", 32'(n_ready_o), 0);
        chk("rst res_valid", 32'(res_valid_o), 0);
        chk("rst res_tag", 32'(res_tag_o), 0);
        chk("rst res_data", 32'(res_data_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst shft_data", 32'(shft_data_o), 0);
        chk("rst shft_value", 32'(shft_value_o), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
    endtask

    typedef struct {
        logic av; logic [SWR-1:0] ad; logic [EWR-1:0] ash; logic alr;
        logic nv; logic [SWR-1:0] nd; logic [EWR-1:0] nsh; logic nlr;
        logic ar; logic nr; logic [EWR-1:0] val;
        logic rv; logic [SWR-1:0] rd; logic rt; logic busy;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [SWR-1:0] ad, input logic [EWR-1:0] ash,
                                input logic alr, input logic nv, input logic [SWR-1:0] nd,
                                input logic [EWR-1:0] nsh, input logic nlr,
                                input logic ar, input logic nr, input logic [EWR-1:0] val,
                                input logic rv, input logic [SWR-1:0] rd, input logic rt,
                                input logic busy);
        vec_t v;
        v.av = av; v.ad = ad; v.ash = ash; v.alr = alr;
        v.nv = nv; v.nd = nd; v.nsh = nsh; v.nlr = nlr;
        v.ar = ar; v.nr = nr; v.val = val; v.rv = rv; v.rd = rd; v.rt = rt; v.busy = busy;
        return v;
    endfunction

    // Reference-model state for the random phase. Each slot is an op
    // issued one or two cycles ago, with its expected result.
    typedef struct {
        bit v; bit [SWR-1:0] res; bit tag; bit lr; bit b;
    } slot_t;

    initial begin
        vec_t vecs[14];
        slot_t s1, s2;
        bit pref_n, a_gr, n_gr;

        //             av ad          ash alr nv nd          nsh nlr ar nr val    rv rd        rt busy
        vecs[0]  = mk(1, 26'h100,  4, 0, 1, 26'h2000, 9, 0, 1, 0, 5'd4,  0, 26'h0,   0, 0);
        vecs[1]  = mk(1, 26'h80,   2, 0, 1, 26'h2000, 9, 0, 0, 1, 5'd1,  0, 26'h0,   0, 1);
        vecs[2]  = mk(1, 26'h80,   2, 0, 1, 26'h1000, 3, 0, 1, 0, 5'hA,  1, 26'h10,  0, 1);
        vecs[3]  = mk(1, 26'h800,  7, 0, 1, 26'h1000, 3, 0, 0, 1, 5'd3,  1, 26'h10,  1, 1);
        vecs[4]  = mk(1, 26'h800,  7, 0, 0, 26'h0,    0, 0, 1, 0, 5'd7,  1, 26'h20,  0, 1);
        vecs[5]  = mk(0, 26'h0,    0, 0, 1, 26'h1,    4, 1, 0, 0, 5'd0,  1, 26'h200, 1, 1);
        vecs[6]  = mk(0, 26'h0,    0, 0, 1, 26'h1,    4, 1, 0, 1, 5'd4,  1, 26'h10,  0, 1);
        vecs[7]  = mk(1, 26'h4,    1, 0, 1, 26'h3,    5, 1, 0, 0, 5'd0,  0, 26'h0,   0, 1);
        vecs[8]  = mk(1, 26'h4,    1, 0, 1, 26'h3,    5, 1, 1, 0, 5'd1,  1, 26'h10,  1, 1);
        vecs[9]  = mk(0, 26'h0,    0, 0, 1, 26'h3,    5, 1, 0, 0, 5'd0,  0, 26'h0,   0, 1);
        vecs[10] = mk(0, 26'h0,    0, 0, 1, 26'h3,    5, 1, 0, 1, 5'd5,  1, 26'h2,   0, 1);
        vecs[11] = mk(0, 26'h0,    0, 0, 0, 26'h0,    0, 0, 0, 0, 5'd0,  0, 26'h0,   0, 1);
        vecs[12] = mk(0, 26'h0,    0, 0, 0, 26'h0,    0, 0, 0, 0, 5'd0,  1, 26'h60,  1, 1);
        vecs[13] = mk(0, 26'h0,    0, 0, 0, 26'h0,    0, 0, 0, 0, 5'd0,  0, 26'h0,   0, 0);

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Table phase. The first row is driven in the first cycle after
        // reset is released.
        for (int i = 0; i < 14; i++) begin
            a_valid_i = vecs[i].av; a_data_i = vecs[i].ad; a_shift_i = vecs[i].ash;
            a_lr_i = vecs[i].alr; a_bit_i = 1'b0;
            n_valid_i = vecs[i].nv; n_data_i = vecs[i].nd; n_shift_i = vecs[i].nsh;
            n_lr_i = vecs[i].nlr; n_bit_i = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d a_ready", i), 32'(a_ready_o), 32'(vecs[i].ar));
            chk($sformatf("vec%0d n_ready", i), 32'(n_ready_o), 32'(vecs[i].nr));
            chk($sformatf("vec%0d shft_value", i), 32'(shft_value_o), 32'(vecs[i].val));
            chk($sformatf("vec%0d res_valid", i), 32'(res_valid_o), 32'(vecs[i].rv));
            chk($sformatf("vec%0d busy", i), 32'(busy_o), 32'(vecs[i].busy));
            if (vecs[i].rv) begin
                chk($sformatf("vec%0d res_data", i), 32'(res_data_o), 32'(vecs[i].rd));
                chk($sformatf("vec%0d res_tag", i), 32'(res_tag_o), 32'(vecs[i].rt));
            end
            @(posedge clk); #1;
        end

        // Reset-abort sequence.
        // An op is issued at T. Reset arrives early in T+1, and that op must
        // never produce a result.
        a_valid_i = 1'b1; a_data_i = 26'hABC; a_shift_i = 5'd0;
        @(negedge clk);
        chk("abort issue a_ready", 32'(a_ready_o), 1);
        @(posedge clk); #1;
        a_data_i = 26'h55; a_shift_i = 5'd1;
        rst = 1'b0;
        #1;
        chk("abort a_ready", 32'(a_ready_o), 0);
        chk("abort shft_data", 32'(shft_data_o), 0);
        chk("abort shft_value", 32'(shft_value_o), 0);
        chk("abort shft_lr", 32'(shft_lr_o), 0);
        chk("abort busy", 32'(busy_o), 0);
        chk("abort res_valid", 32'(res_valid_o), 0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort post res_valid %0d", i), 32'(res_valid_o), 0);
            @(posedge clk); #1;
        end

        // Random phase, checked against the reference model.
        do_reset();
        s1 = '{default: 0}; s2 = '{default: 0}; pref_n = 1'b0;
        a_gr = 1'b0; n_gr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bit has_c, c_n, c_lr, c_b, stall, grant;
            bit [SWR-1:0] c_data;
            bit [EWR-1:0] c_sh;
            // A requester that is waiting holds its op; otherwise it may
            // present a new one.
            if (!(a_valid_i && !a_gr)) begin
                a_valid_i = (i < 396) && ($urandom_range(0, 9) < 7);
                a_data_i  = SWR'($urandom);
                a_shift_i = EWR'($urandom_range(0, 31));
                a_lr_i    = ($urandom_range(0, 3) == 0);
                a_bit_i   = ($urandom_range(0, 5) == 0);
            end
            if (!(n_valid_i && !n_gr)) begin
                n_valid_i = (i < 396) && ($urandom_range(0, 9) < 7);
                n_data_i  = SWR'($urandom);
                n_shift_i = EWR'($urandom_range(0, 31));
                n_lr_i    = ($urandom_range(0, 3) == 0);
                n_bit_i   = ($urandom_range(0, 5) == 0);
            end
            @(negedge clk);
            has_c  = a_valid_i || n_valid_i;
            c_n    = (a_valid_i && n_valid_i) ? pref_n : n_valid_i;
            c_lr   = c_n ? n_lr_i : a_lr_i;
            c_b    = c_n ? n_bit_i : a_bit_i;
            c_data = c_n ? n_data_i : a_data_i;
            c_sh   = c_n ? n_shift_i : a_shift_i;
            stall  = s1.v && ((c_lr != s1.lr) || (c_b != s1.b));
            grant  = has_c && !stall;
            a_gr   = grant && !c_n;
            n_gr   = grant && c_n;
            chk($sformatf("rnd%0d a_ready", i), 32'(a_ready_o), 32'(a_gr));
            chk($sformatf("rnd%0d n_ready", i), 32'(n_ready_o), 32'(n_gr));
            chk($sformatf("rnd%0d busy", i), 32'(busy_o), 32'(s1.v | s2.v));
            chk($sformatf("rnd%0d res_valid", i), 32'(res_valid_o), 32'(s2.v));
            if (s2.v) begin
                chk($sformatf("rnd%0d res_data", i), 32'(res_data_o), 32'(s2.res));
                chk($sformatf("rnd%0d res_tag", i), 32'(res_tag_o), 32'(s2.tag));
            end
            s2 = s1;
            if (grant) begin
                s1.v = 1'b1; s1.res = shf(c_data, 32'(c_sh), c_lr, c_b);
                s1.tag = c_n; s1.lr = c_lr; s1.b = c_b;
                pref_n = !c_n;
            end else begin
                s1 = '{default: 0};
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
